cycle_sequencer: RTL and testbench

Instruction-cycle controller for the 14-bit-instruction core. It divides each instruction into four clock phases (Q1–Q4) and owns the instruction register. It emits the per-phase strobes that drive the instruction memory, ALU, W/file-register writes, program counter and call stack. It also implements the one-cycle flush (forced NOP) after taken branches and taken skips, and tracks call-stack depth with overflow and underflow protection.

---
 rtl/cycle_sequencer_if.sv | 46 ++++
 rtl/cycle_sequencer.sv | 120 ++++++++++++
 tb/tb_cycle_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cycle_sequencer_if.sv
// Bundle of decoder inputs, memory/ALU inputs and per-phase strobes of cycle_sequencer.
// The sequencer uses the slave modport; whatever drives the decoder side uses master.
interface cycle_sequencer_if #(
    parameter int unsigned STACK_DEPTH = 8
);
    localparam int unsigned DepthW = $clog2(STACK_DEPTH) + 1;

    logic              hold;
    logic [13:0]       imem_data;
    logic              dec_reg_we;
    logic              dec_w_we;
    logic              dec_branch;
    logic              dec_push;
    logic              dec_pop;
    logic              dec_skip;
    logic              alu_zero;

    logic [1:0]        phase;
    logic [13:0]       ir;
    logic              imem_en;
    logic              alu_en;
    logic              reg_we;
    logic              w_we;
    logic              pc_inc;
    logic              pc_load;
    logic              stack_push;
    logic              stack_pop;
    logic [DepthW-1:0] stack_depth;
    logic              flushed;
    logic              stack_ovf;
    logic              stack_unf;

    modport master (
        output hold, imem_data, dec_reg_we, dec_w_we, dec_branch, dec_push, dec_pop,
               dec_skip, alu_zero,
        input  phase, ir, imem_en, alu_en, reg_we, w_we, pc_inc, pc_load, stack_push,
               stack_pop, stack_depth, flushed, stack_ovf, stack_unf
    );

    modport slave (
        input  hold, imem_data, dec_reg_we, dec_w_we, dec_branch, dec_push, dec_pop,
               dec_skip, alu_zero,
        output phase, ir, imem_en, alu_en, reg_we, w_we, pc_inc, pc_load, stack_push,
               stack_pop, stack_depth, flushed, stack_ovf, stack_unf
    );
endinterface

// File: rtl/cycle_sequencer.sv
// Four-phase instruction-cycle controller: owns IR, emits per-phase strobes,
// forces a NOP cycle after taken branches/skips and guards the call-stack depth.
module cycle_sequencer #(
    parameter int unsigned STACK_DEPTH = 8
) (
    input logic              clk,
    input logic              reset,
    cycle_sequencer_if.slave bus
);
    localparam int unsigned DepthW = $clog2(STACK_DEPTH) + 1;
    localparam logic [DepthW-1:0] DepthFull = DepthW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        StQ1 = 2'd0,
        StQ2 = 2'd1,
        StQ3 = 2'd2,
        StQ4 = 2'd3
    } phase_e;

    phase_e            phase_q, phase_d;
    logic [13:0]       ir_q, ir_d;
    logic              flushed_q, flushed_d;
    logic [DepthW-1:0] depth_q, depth_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic active, exec, br_exec, push_req, pop_req, full, empty;
    logic imem_en, alu_en, reg_we, w_we, pc_inc, pc_load, stack_push, stack_pop;

    always_comb begin
        active   = ~reset & ~bus.hold;
        exec     = ~flushed_q;
        br_exec  = bus.dec_branch & exec;
        push_req = bus.dec_push & exec;
        // Push wins when the decoder flags both.
        pop_req  = bus.dec_pop & ~bus.dec_push & exec;
        full     = (depth_q == DepthFull);
        empty    = (depth_q == '0);

        imem_en    = 1'b0;
        alu_en     = 1'b0;
        reg_we     = 1'b0;
        w_we       = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        phase_d    = phase_q;
        ir_d       = ir_q;
        flushed_d  = flushed_q;
        depth_d    = depth_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (active) begin
            unique case (phase_q)
                StQ1: phase_d = StQ2;
                StQ2: phase_d = StQ3;
                StQ3: begin
                    phase_d = StQ4;
                    alu_en  = 1'b1;
                    imem_en = 1'b1;
                end
                StQ4: begin
                    phase_d    = StQ1;
                    ir_d       = bus.imem_data;
                    reg_we     = bus.dec_reg_we & exec;
                    w_we       = bus.dec_w_we & exec;
                    pc_load    = br_exec;
                    pc_inc     = ~br_exec;
                    stack_push = push_req & ~full;
                    stack_pop  = pop_req & ~empty;
                    ovf_d      = ovf_q | (push_req & full);
                    unf_d      = unf_q | (pop_req & empty);
                    if (stack_push) begin
                        depth_d = depth_q + 1'b1;
                    end else if (stack_pop) begin
                        depth_d = depth_q - 1'b1;
                    end
                    // A flushed cycle cannot flush its successor since exec gates both terms.
                    flushed_d  = br_exec | (bus.dec_skip & bus.alu_zero & exec);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= StQ1;
            ir_q      <= '0;
            flushed_q <= 1'b1;
            depth_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            ir_q      <= ir_d;
            flushed_q <= flushed_d;
            depth_q   <= depth_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.ir          = ir_q;
    assign bus.imem_en     = imem_en;
    assign bus.alu_en      = alu_en;
    assign bus.reg_we      = reg_we;
    assign bus.w_we        = w_we;
    assign bus.pc_inc      = pc_inc;
    assign bus.pc_load     = pc_load;
    assign bus.stack_push  = stack_push;
    assign bus.stack_pop   = stack_pop;
    assign bus.stack_depth = depth_q;
    assign bus.flushed     = flushed_q;
    assign bus.stack_ovf   = ovf_q;
    assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: directed scenarios plus random traffic, all checked
// every clock against an instruction-level model kept in the bench.
module tb_cycle_sequencer;
    localparam int unsigned Depth = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cycle_sequencer_if #(.STACK_DEPTH(Depth)) bus ();

    cycle_sequencer #(.STACK_DEPTH(Depth)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: clocks advanced, flush flag, stack contents as a queue.
    int          m_adv;
    bit [13:0]   m_ir;
    bit          m_fl, m_ovf, m_unf, m_valid;
    int          m_stk[$];
    int          pc_inc_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_dec(input bit rw, input bit ww, input bit br, input bit pu, input bit po,
                           input bit sk, input bit az);
        bus.dec_reg_we = rw;
        bus.dec_w_we   = ww;
        bus.dec_branch = br;
        bus.dec_push   = pu;
        bus.dec_pop    = po;
        bus.dec_skip   = sk;
        bus.alu_zero   = az;
        bus.imem_data  = 14'($urandom);
    endtask

    // One clock: compare all outputs mid-cycle, then advance the model on the edge.
    task automatic step();
        logic [7:0] exp_strb, got_strb;
        int  ph;
        bit  exec, br;
        @(negedge clk);
        ph   = m_adv % 4;
        exec = !m_fl;
        br   = bus.dec_branch && exec;
        exp_strb = '0;
        if (!reset && !bus.hold) begin
            if (ph == 2) exp_strb[7:6] = 2'b11;
            if (ph == 3) begin
                exp_strb[5] = bus.dec_reg_we && exec;
                exp_strb[4] = bus.dec_w_we && exec;
                exp_strb[3] = !br;
                exp_strb[2] = br;
                exp_strb[1] = bus.dec_push && exec && (m_stk.size() < Depth);
                exp_strb[0] = bus.dec_pop && !bus.dec_push && exec && (m_stk.size() > 0);
            end
        end
        got_strb = {bus.imem_en, bus.alu_en, bus.reg_we, bus.w_we, bus.pc_inc, bus.pc_load,
                    bus.stack_push, bus.stack_pop};
        pc_inc_cnt += int'(bus.pc_inc === 1'b1);
        if (m_valid) begin
            check_eq("phase", 32'(bus.phase), 32'(ph));
            check_eq("ir", 32'(bus.ir), 32'(m_ir));
            check_eq("strobes", 32'(got_strb), 32'(exp_strb));
            check_eq("flushed", 32'(bus.flushed), 32'(m_fl));
            check_eq("depth", 32'(bus.stack_depth), 32'(m_stk.size()));
            check_eq("ovf", 32'(bus.stack_ovf), 32'(m_ovf));
            check_eq("unf", 32'(bus.stack_unf), 32'(m_unf));
        end else begin
            check_eq("rst_strobes", 32'(got_strb), 32'(exp_strb));
        end
        @(posedge clk);
        if (reset) begin
            m_adv = 0; m_ir = '0; m_fl = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
            m_stk.delete();
            m_valid = 1'b1;
        end else if (!bus.hold) begin
            if (ph == 3) begin
                m_ir = bus.imem_data;
                if (exec && bus.dec_push) begin
                    if (m_stk.size() < Depth) m_stk.push_back(int'($urandom_range(0, 2047)));
                    else m_ovf = 1'b1;
                end else if (exec && bus.dec_pop) begin
                    if (m_stk.size() > 0) void'(m_stk.pop_back());
                    else m_unf = 1'b1;
                end
                m_fl = br || (bus.dec_skip && bus.alu_zero && exec);
            end
            m_adv++;
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n;
        m_valid = 1'b0;
        m_adv = 0;
        pc_inc_cnt = 0;
        reset    = 1'b1;
        bus.hold = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0);
        steps(2);
        reset = 1'b0;

        // Idle cycles: first cycle flushed, pc_inc once per instruction.
        pc_inc_cnt = 0;
        steps(12);
        check_eq("idle_pc_inc_count", 32'(pc_inc_cnt), 32'd3);

        // Branch with reg write, then a flushed cycle with the same decode.
        set_dec(1, 1, 1, 0, 0, 0, 0);
        steps(8);
        set_dec(0, 0, 0, 0, 0, 1, 1);
        steps(8);
        set_dec(0, 0, 0, 0, 0, 1, 0);
        steps(8);

        // Calls until overflow, then returns until underflow.
        set_dec(0, 0, 1, 1, 0, 0, 0);
        steps(80);
        check_eq("call_depth_full", 32'(bus.stack_depth), 32'(Depth));
        check_eq("call_ovf", 32'(bus.stack_ovf), 32'd1);
        set_dec(0, 0, 1, 0, 1, 0, 0);
        steps(80);
        check_eq("ret_depth_empty", 32'(bus.stack_depth), 32'd0);
        check_eq("ret_unf", 32'(bus.stack_unf), 32'd1);
        set_dec(0, 0, 1, 1, 1, 0, 0);
        steps(8);
        check_eq("push_pop_push_wins", 32'(bus.stack_depth), 32'd1);

        // Hold for three clocks entering Q2.
        set_dec(0, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (m_adv % 4 != 1 && n < 8) begin step(); n++; end
        bus.hold = 1'b1;
        steps(3);
        bus.hold = 1'b0;
        steps(6);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            bus.hold = ($urandom_range(0, 7) == 0);
            set_dec(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom), 1'($urandom));
            step();
        end

        // Reset during Q3 with hold high, stack partially full and overflow flagged.
        reset = 1'b1; bus.hold = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        set_dec(0, 0, 1, 1, 0, 0, 0);
        steps(80);
        set_dec(0, 0, 1, 0, 1, 0, 0);
        n = 0;
        while (m_stk.size() > 3 && n < 200) begin step(); n++; end
        set_dec(0, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (m_adv % 4 != 2 && n < 8) begin step(); n++; end
        check_eq("pre_rst_depth", 32'(bus.stack_depth), 32'd3);
        check_eq("pre_rst_ovf", 32'(bus.stack_ovf), 32'd1);
        reset = 1'b1; bus.hold = 1'b1;
        step();
        reset = 1'b0; bus.hold = 1'b0;
        check_eq("rst_phase", 32'(bus.phase), 32'd0);
        check_eq("rst_flushed", 32'(bus.flushed), 32'd1);
        check_eq("rst_depth", 32'(bus.stack_depth), 32'd0);
        check_eq("rst_flags", 32'({bus.stack_ovf, bus.stack_unf}), 32'd0);
        steps(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
